led_scan_ctrl: RTL and testbench

- Parametrised, memory-mapped, time-multiplexed LED/7-segment display driver on the CPU data bus.
- Holds one segment register per digit plus a control register.
- Scans the digits with one-hot active-low digit selects.
- Generalises the fixed 4-digit driver: digit count, segment width, scan period and base address are parameters.
- Adds a write-enable-qualified bus, registered readback, display enable and optional brightness PWM.

---
 rtl/led_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_led_scan_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_ctrl.sv
// Memory-mapped, time-multiplexed LED/7-segment driver with one-hot active-low digit selects.
// Optional brightness PWM is compiled in when LED_SCAN_PWM_EN is defined.
module led_scan_ctrl #(
    parameter int unsigned       NUM_DIGITS = 4,
    parameter int unsigned       SEG_W      = 8,
    parameter int unsigned       ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 8'hF0,
    parameter int unsigned       SCAN_DIV   = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [SEG_W-1:0]      wdata,
    output logic [SEG_W-1:0]      rdata,
    output logic [NUM_DIGITS-1:0] dig_n,
    output logic [SEG_W-1:0]      seg
);

    localparam int unsigned       CNT_W    = $clog2(SCAN_DIV);
    localparam int unsigned       IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [ADDR_W-1:0] LAST_OFF = ADDR_W'(NUM_DIGITS);
    localparam logic [SEG_W-1:0]  CTRL_RST = SEG_W'(8'h0F);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [SEG_W-1:0]      digit_q [NUM_DIGITS];
    logic [SEG_W-1:0]      digit_d [NUM_DIGITS];
    logic [SEG_W-1:0]      ctrl_q, ctrl_d;
    logic [SEG_W-1:0]      rdata_q, rdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [SEG_W-1:0]      slot_seg_q, slot_seg_d;
    logic [NUM_DIGITS-1:0] slot_sel_q, slot_sel_d;
    logic                  slot_en_q, slot_en_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_n_q, dig_n_d;

    logic [ADDR_W-1:0] off;
    logic              in_range;
    logic              slot_start;
    logic              pwm_on;
    logic              lit;

    assign off      = addr - BASE_ADDR;
    assign in_range = (addr >= BASE_ADDR) && (off <= LAST_OFF);

    // Register file: write port and registered readback (old value on same-cycle write).
    always_comb begin
        digit_d = digit_q;
        ctrl_d  = ctrl_q;
        rdata_d = '0;
        if (in_range) begin
            if (off == LAST_OFF) begin
                rdata_d = ctrl_q;
            end
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                if (off == ADDR_W'(k)) begin
                    rdata_d = digit_q[k];
                end
            end
        end
        if (we && in_range) begin
            if (off == LAST_OFF) begin
                ctrl_d = wdata;
            end
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                if (off == ADDR_W'(k)) begin
                    digit_d[k] = wdata;
                end
            end
        end
    end

`ifdef LED_SCAN_PWM_EN
    assign pwm_on = (cnt_q[CNT_W-1 -: 3] <= ctrl_q[3:1]);
`else
    assign pwm_on = 1'b1;
`endif

    // Scan engine: segment data is latched only at slot start; enable gates every cycle
    // but a slot disabled part-way stays dark until the next slot boundary.
    always_comb begin
        cnt_d      = cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        slot_seg_d = slot_seg_q;
        slot_sel_d = slot_sel_q;
        slot_start = (cnt_q == '0);
        slot_en_d  = slot_en_q & ctrl_q[0];
        if (slot_start) begin
            slot_en_d  = ctrl_q[0];
            slot_sel_d = NUM_DIGITS'(1) << idx_q;
            idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    slot_seg_d = digit_q[k];
                end
            end
        end
        lit     = slot_en_d & pwm_on;
        seg_d   = lit ? slot_seg_d : '0;
        dig_n_d = lit ? ~slot_sel_d : '1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_q    <= '{default: '0};
            ctrl_q     <= CTRL_RST;
            rdata_q    <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            slot_seg_q <= '0;
            slot_sel_q <= '0;
            slot_en_q  <= 1'b0;
            seg_q      <= '0;
            dig_n_q    <= '1;
        end else begin
            digit_q    <= digit_d;
            ctrl_q     <= ctrl_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            slot_seg_q <= slot_seg_d;
            slot_sel_q <= slot_sel_d;
            slot_en_q  <= slot_en_d;
            seg_q      <= seg_d;
            dig_n_q    <= dig_n_d;
        end
    end

    assign rdata = rdata_q;
    assign seg   = seg_q;
    assign dig_n = dig_n_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=16); PWM expectations follow LED_SCAN_PWM_EN.
module tb_led_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       we = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic [3:0] dig_n;
    logic [7:0] seg;

    int checks = 0;
    int errors = 0;

`ifdef LED_SCAN_PWM_EN
    localparam bit PWM = 1'b1;
`else
    localparam bit PWM = 1'b0;
`endif

    always #5 clk = ~clk;

    led_scan_ctrl #(
        .NUM_DIGITS(4),
        .SEG_W     (8),
        .ADDR_W    (8),
        .BASE_ADDR (8'hF0),
        .SCAN_DIV  (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .addr (addr),
        .wdata(wdata),
        .rdata(rdata),
        .dig_n(dig_n),
        .seg  (seg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        addr = a;
        tick();
        chk(tag, rdata, exp);
    endtask

    task automatic wait_dig(input logic [3:0] exp);
        for (int i = 0; i < 100 && dig_n !== exp; i++) tick();
        chk("wait_dig", dig_n, exp);
    endtask

    // Wait for a digit to light, then measure how many cycles it stays lit with the given data.
    task automatic slot(input string tag, input logic [3:0] d, input logic [7:0] s, input int len);
        int n;
        wait_dig(d);
        chk({tag, "_seg"}, seg, s);
        n = 0;
        while (n < 40 && dig_n === d && seg === s) begin
            n++;
            tick();
        end
        chk({tag, "_len"}, 32'(n), 32'(len));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] regs [5];
        logic [3:0] d;
        logic [7:0] e;
        int         n;
        regs = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h0F};

        // Reset state
        tick();
        tick();
        chk("rst_dig_n", dig_n, 4'hF);
        chk("rst_seg", seg, 8'h00);
        chk("rst_rdata", rdata, 8'h00);

        // Release: digit 0 comes up first; we=0 must not write
        rst_n = 1'b1;
        addr  = 8'hF1;
        wdata = 8'hAA;
        tick();
        chk("first_slot_dig", dig_n, 4'b1110);
        chk("first_slot_seg", seg, 8'h00);
        tick();
        chk("we0_rdata", rdata, 8'h00);
        slot("we0_slot", 4'b1101, 8'h00, 16);

        // Same-cycle write/read returns old value, then new
        we = 1'b1;
        tick();
        we = 1'b0;
        chk("rw_same_cycle_old", rdata, 8'h00);
        tick();
        chk("rd_after_wr", rdata, 8'hAA);

        wr(8'hF0, 8'h11);
        wr(8'hF1, 8'h22);
        wr(8'hF2, 8'h33);
        wr(8'hF3, 8'h44);
        rd("ctrl_reset_val", 8'hF4, 8'h0F);

        slot("scan_d3", 4'b0111, 8'h44, 16);
        slot("scan_d0", 4'b1110, 8'h11, 16);
        slot("scan_d1", 4'b1101, 8'h22, 16);
        slot("scan_d2", 4'b1011, 8'h33, 16);

        // Out-of-range write ignored, reads 0, other registers unchanged
        wr(8'hF5, 8'h55);
        rd("oob_read", 8'hF5, 8'h00);
        for (int i = 0; i < 5; i++) rd("reg_readback", 8'(8'hF0 + i), regs[i]);

        // Disable blanks the display on the following cycle and keeps it dark
        wr(8'hF4, 8'h0E);
        tick();
        chk("dis_dig_n", dig_n, 4'hF);
        chk("dis_seg", seg, 8'h00);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (dig_n !== 4'hF || seg !== 8'h00) n++;
            tick();
        end
        chk("dis_dark", 32'(n), 32'd0);

        // Re-enable resumes on a slot boundary: first lit digit holds a full slot
        wr(8'hF4, 8'h0F);
        for (int i = 0; i < 60 && dig_n === 4'hF; i++) tick();
        d = dig_n;
        chk("reen_onehot", 32'($countones(~d)), 32'd1);
        e = (d == 4'b1110) ? 8'h11 : (d == 4'b1101) ? 8'h22 : (d == 4'b1011) ? 8'h33 : 8'h44;
        chk("reen_seg", seg, e);
        n = 0;
        while (n < 40 && dig_n === d) begin
            n++;
            tick();
        end
        chk("reen_len", 32'(n), 32'd16);

        // Reset mid-slot with digit 2 active
        wait_dig(4'b1011);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("mrst_dig_n", dig_n, 4'hF);
        chk("mrst_seg", seg, 8'h00);
        chk("mrst_rdata", rdata, 8'h00);
        tick();
        rst_n = 1'b1;
        addr  = 8'hF2;
        tick();
        chk("mrst_first_dig", dig_n, 4'b1110);
        chk("mrst_first_seg", seg, 8'h00);
        chk("mrst_d2_cleared", rdata, 8'h00);
        rd("mrst_ctrl", 8'hF4, 8'h0F);
        rd("mrst_d0_cleared", 8'hF0, 8'h00);

        // Write during the active slot is not shown until the next slot of that digit
        wr(8'hF0, 8'h77);
        tick();
        chk("midslot_dig", dig_n, 4'b1110);
        chk("midslot_hidden", seg, 8'h00);
        wait_dig(4'b1101);
        slot("next_slot_new", 4'b1110, 8'h77, 16);

        // Brightness duty
        wr(8'hF0, 8'h5A);
        wr(8'hF4, 8'h03);
        wait_dig(4'b1011);
        slot("duty1", 4'b1110, 8'h5A, PWM ? 4 : 16);
        wr(8'hF4, 8'h01);
        wait_dig(4'b1011);
        slot("duty0", 4'b1110, 8'h5A, PWM ? 2 : 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
